// File: rtl/ula_acc_seq.sv
// Sequential ALU with a signed accumulator as operand A, status flags, a valid/ready
// input handshake and an iterative one-bit-per-cycle shifter for SHL/SAR.
module ula_acc_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_out,
  output logic             out_valid,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int SHW = $clog2(WIDTH) + 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh_reg;
  logic [SHW-1:0]   cnt;
  logic             sh_left;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   n_sat;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;
  logic             is_shift;

  assign acc_out  = acc;
  assign in_ready = (state == IDLE);

  // Shift amount is ACC read as unsigned, clamped to WIDTH so the counter stays small.
  assign n_sat    = (acc >= WIDTH'(WIDTH)) ? SHW'(WIDTH) : SHW'(acc);
  assign is_shift = (op == 4'd6) || (op == 4'd7);
  assign sum      = {1'b0, acc} + {1'b0, b};
  assign diff     = b - acc;

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      4'd0: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (acc[MSB] == b[MSB]) && (sum[MSB] != acc[MSB]);
      end
      4'd1: begin
        res   = diff;
        res_c = (b < acc);
        res_v = (b[MSB] != acc[MSB]) && (diff[MSB] != b[MSB]);
      end
      4'd2:    res = acc & b;
      4'd3:    res = acc | b;
      4'd4:    res = acc ^ b;
      4'd5:    res = ~b;
      // Only reached for a zero shift amount; nonzero amounts go through SHIFT.
      4'd6:    res = b;
      4'd7:    res = b;
      4'd8:    res = b;
      default: res = '0;
    endcase
  end

  always_comb begin
    sh_next = '0;
    sh_out  = 1'b0;
    if (sh_left) begin
      sh_next = {sh_reg[WIDTH-2:0], 1'b0};
      sh_out  = sh_reg[MSB];
    end else begin
      sh_next = {sh_reg[MSB], sh_reg[WIDTH-1:1]};
      sh_out  = sh_reg[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      sh_reg    <= '0;
      cnt       <= '0;
      sh_left   <= 1'b0;
      out_valid <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift && (n_sat != '0)) begin
              sh_reg  <= b;
              cnt     <= n_sat;
              sh_left <= (op == 4'd6);
              state   <= SHIFT;
            end else begin
              acc       <= res;
              flag_z    <= (res == '0);
              flag_n    <= res[MSB];
              flag_c    <= res_c;
              flag_v    <= res_v;
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          sh_reg <= sh_next;
          cnt    <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            acc       <= sh_next;
            flag_z    <= (sh_next == '0);
            flag_n    <= sh_next[MSB];
            flag_c    <= sh_out;
            flag_v    <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_acc_seq.sv
// Directed bench for ula_acc_seq: a table of back-to-back single-cycle ops, then
// hand-written sequences for the multi-cycle shifter and reset during a shift.
module tb_ula_acc_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc_out;
  logic             out_valid;
  logic             flag_z, flag_n, flag_c, flag_v;

  int n_cmp  = 0;
  int n_fail = 0;

  // Flags packed as {z, n, c, v}.
  typedef struct {
    logic [3:0] op;
    logic [7:0] b;
    logic [7:0] acc;
    logic [3:0] flags;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  ula_acc_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .b         (b),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [3:0] o, input logic [7:0] bv);
    in_valid = v;
    op       = o;
    b        = bv;
  endtask

  // Issue one single-cycle op from a falling edge; returns on the next falling edge.
  task automatic do_op(input logic [3:0] o, input logic [7:0] bv);
    apply_stimulus(1'b1, o, bv);
    @(negedge clk);
    apply_stimulus(1'b0, 4'd0, 8'h00);
  endtask

  // Issue a shift, pulse LOAD requests while busy (they must be ignored), then check result.
  task automatic run_shift(input string name, input logic [3:0] o, input logic [7:0] bv,
                           input int exp_busy, input logic [7:0] prev_acc,
                           input logic [7:0] exp_acc, input logic [3:0] exp_flags);
    int   busy  = 0;
    int   stray = 0;
    logic done  = 1'b0;
    apply_stimulus(1'b1, o, bv);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        done = 1'b1;
        apply_stimulus(1'b0, 4'd0, 8'h00);
      end else begin
        busy++;
        if (in_ready !== 1'b0 || acc_out !== prev_acc) stray++;
        apply_stimulus((busy % 2) == 1, 4'd8, 8'h11);
      end
    end
    apply_stimulus(1'b0, 4'd0, 8'h00);
    check_output({name, " done"}, done, 1'b1);
    check_output({name, " busy cycles"}, busy, exp_busy);
    check_output({name, " busy state"}, stray, 0);
    check_output({name, " acc"}, acc_out, exp_acc);
    check_output({name, " flags"}, {flag_z, flag_n, flag_c, flag_v}, exp_flags);
    @(negedge clk);
    check_output({name, " pulse end"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ov_count;

    vecs[0]  = '{4'd8, 8'h7F, 8'h7F, 4'b0000};
    vecs[1]  = '{4'd0, 8'h01, 8'h80, 4'b0101};
    vecs[2]  = '{4'd8, 8'h05, 8'h05, 4'b0000};
    vecs[3]  = '{4'd1, 8'h03, 8'hFE, 4'b0110};
    vecs[4]  = '{4'd8, 8'hFF, 8'hFF, 4'b0100};
    vecs[5]  = '{4'd0, 8'h01, 8'h00, 4'b1010};
    vecs[6]  = '{4'd8, 8'h01, 8'h01, 4'b0000};
    vecs[7]  = '{4'd1, 8'h80, 8'h7F, 4'b0001};
    vecs[8]  = '{4'd8, 8'h80, 8'h80, 4'b0100};
    vecs[9]  = '{4'd0, 8'h80, 8'h00, 4'b1011};
    vecs[10] = '{4'd8, 8'h0F, 8'h0F, 4'b0000};
    vecs[11] = '{4'd2, 8'h3C, 8'h0C, 4'b0000};
    vecs[12] = '{4'd3, 8'h30, 8'h3C, 4'b0000};
    vecs[13] = '{4'd4, 8'hFF, 8'hC3, 4'b0100};
    vecs[14] = '{4'd5, 8'h55, 8'hAA, 4'b0100};
    vecs[15] = '{4'd12, 8'h77, 8'h00, 4'b1000};
    vecs[16] = '{4'd8, 8'h12, 8'h12, 4'b0000};
    vecs[17] = '{4'd9, 8'hFF, 8'h00, 4'b1000};
    vecs[18] = '{4'd8, 8'h00, 8'h00, 4'b1000};
    vecs[19] = '{4'd6, 8'h5A, 8'h5A, 4'b0000};
    vecs[20] = '{4'd8, 8'h00, 8'h00, 4'b1000};
    vecs[21] = '{4'd7, 8'h85, 8'h85, 4'b0100};

    rst_n = 1'b0;
    apply_stimulus(1'b0, 4'd0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset acc", acc_out, 8'h00);
    check_output("reset flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    check_output("reset out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("reset in_ready", in_ready, 1'b1);

    // Back-to-back accepts: every vector completes with a pulse on the following cycle.
    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(1'b1, vecs[i].op, vecs[i].b);
      @(negedge clk);
      check_output($sformatf("vec%0d out_valid", i), out_valid, 1'b1);
      check_output($sformatf("vec%0d acc", i), acc_out, vecs[i].acc);
      check_output($sformatf("vec%0d flags", i), {flag_z, flag_n, flag_c, flag_v}, vecs[i].flags);
      check_output($sformatf("vec%0d in_ready", i), in_ready, 1'b1);
    end
    apply_stimulus(1'b0, 4'd0, 8'h00);
    @(negedge clk);
    check_output("idle out_valid", out_valid, 1'b0);
    check_output("idle acc hold", acc_out, 8'h85);

    do_op(4'd8, 8'h03);
    run_shift("shl3", 4'd6, 8'h81, 3, 8'h03, 8'h08, 4'b0000);
    do_op(4'd8, 8'h09);
    run_shift("sar9", 4'd7, 8'h80, 8, 8'h09, 8'hFF, 4'b0110);
    do_op(4'd8, 8'h20);
    run_shift("shl32", 4'd6, 8'hFF, 8, 8'h20, 8'h00, 4'b1010);
    do_op(4'd8, 8'h00);
    run_shift("shl0", 4'd6, 8'h5A, 0, 8'h00, 8'h5A, 4'b0000);
    do_op(4'd8, 8'h02);
    run_shift("sar2", 4'd7, 8'h81, 2, 8'h02, 8'hE0, 4'b0100);

    // Reset on the second shift edge aborts the op without a completion pulse.
    do_op(4'd8, 8'h06);
    apply_stimulus(1'b1, 4'd7, 8'h40);
    @(negedge clk);
    apply_stimulus(1'b0, 4'd0, 8'h00);
    check_output("abort busy", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("abort acc", acc_out, 8'h00);
    check_output("abort out_valid", out_valid, 1'b0);
    check_output("abort in_ready", in_ready, 1'b1);
    check_output("abort flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    ov_count = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ov_count++;
    end
    check_output("abort no pulse", ov_count, 0);
    check_output("abort acc hold", acc_out, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
